tile_rom_arbiter: RTL and testbench

//  Shares one single-port tile colour ROM (TILE_W x TILE_H texels, 1-cycle registered read) between
//  two pixel requesters: board renderer (port 0) and next-piece preview (port 1).

---
 rtl/tile_rom_arbiter_if.sv | 30 +++
 rtl/tile_rom_arbiter.sv | 85 ++++++++
 tb/tb_tile_rom_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tile_rom_arbiter_if.sv
// Request, ROM and response signals shared by the tile ROM arbiter and its neighbours.
// The arbiter takes the slave modport; requesters, ROM and consumers together form the master side.
interface tile_rom_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 24
);
  logic              req0_valid;
  logic [4:0]        req0_x;
  logic [4:0]        req0_y;
  logic              req0_ready;
  logic              req1_valid;
  logic [4:0]        req1_x;
  logic [4:0]        req1_y;
  logic              req1_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;

  modport slave (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, rom_data,
    output req0_ready, req1_ready, rom_addr, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, rom_data,
    input  req0_ready, req1_ready, rom_addr, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/tile_rom_arbiter.sv
// Round-robin sharing of one registered-read tile colour ROM between two texel requesters,
// with (x,y) to linear address conversion, out-of-range masking and id-tagged responses.
module tile_rom_arbiter #(
  parameter int unsigned             TILE_W    = 20,
  parameter int unsigned             TILE_H    = 20,
  parameter int unsigned             ADDR_W    = 9,
  parameter int unsigned             DATA_W    = 24,
  parameter logic [DATA_W-1:0]       OOR_COLOR = '0
) (
  input logic               Clk,
  input logic               Reset,
  tile_rom_arbiter_if.slave bus
);

  logic              grant0;
  logic              grant1;
  logic              rr_q;
  logic [4:0]        sel_x;
  logic [4:0]        sel_y;
  logic              sel_oor;
  logic [ADDR_W-1:0] lin_addr;

  logic              s1_valid_q;
  logic              s1_id_q;
  logic              s1_oor_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              s2_valid_q;
  logic              s2_id_q;
  logic              s2_oor_q;

  // rr_q names the port that wins when both request in the same cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!Reset) begin
      if (bus.req0_valid && (!bus.req1_valid || !rr_q)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    sel_x    = grant1 ? bus.req1_x : bus.req0_x;
    sel_y    = grant1 ? bus.req1_y : bus.req0_y;
    sel_oor  = (32'(sel_x) >= TILE_W) || (32'(sel_y) >= TILE_H);
    lin_addr = ADDR_W'(sel_y) * ADDR_W'(TILE_W) + ADDR_W'(sel_x);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_q       <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_oor_q   <= 1'b0;
      rom_addr_q <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
      s2_oor_q   <= 1'b0;
    end else begin
      s1_valid_q <= grant0 | grant1;
      s1_id_q    <= grant1;
      s1_oor_q   <= sel_oor;
      // Out-of-range requests leave the ROM address alone; their data is masked later.
      if ((grant0 || grant1) && !sel_oor) begin
        rom_addr_q <= lin_addr;
      end
      if (grant0 || grant1) begin
        rr_q <= grant0;
      end
      s2_valid_q <= s1_valid_q;
      s2_id_q    <= s1_id_q;
      s2_oor_q   <= s1_oor_q;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.rsp_valid  = s2_valid_q;
  assign bus.rsp_id     = s2_id_q;
  assign bus.rsp_data   = s2_oor_q ? OOR_COLOR : bus.rom_data;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Directed vector bench for tile_rom_arbiter with a registered-read ROM model.
module tb_tile_rom_arbiter;

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;

  tile_rom_arbiter_if #(.ADDR_W(9), .DATA_W(24)) bus ();

  tile_rom_arbiter #(
    .TILE_W   (20),
    .TILE_H   (20),
    .ADDR_W   (9),
    .DATA_W   (24),
    .OOR_COLOR(24'h000000)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [23:0] rom_word(input logic [8:0] a);
    return 24'h0A0000 | (24'(a) * 24'd37);
  endfunction

  logic [23:0] rom_q;
  always @(posedge Clk) rom_q <= rom_word(bus.rom_addr);
  assign bus.rom_data = rom_q;

  typedef struct {
    logic       v0;
    logic [4:0] x0;
    logic [4:0] y0;
    logic       v1;
    logic [4:0] x1;
    logic [4:0] y1;
    logic       r0;
    logic       r1;
    logic [8:0] addr;
    logic       rv;
    logic       rid;
    logic       roor;
    logic [8:0] daddr;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic v0, input int x0, input int y0,
                              input logic v1, input int x1, input int y1,
                              input logic r0, input logic r1, input int addr,
                              input logic rv, input logic rid, input logic roor,
                              input int daddr);
    vec_t v;
    v.v0 = v0; v.x0 = 5'(x0); v.y0 = 5'(y0);
    v.v1 = v1; v.x1 = 5'(x1); v.y1 = 5'(y1);
    v.r0 = r0; v.r1 = r1; v.addr = 9'(addr);
    v.rv = rv; v.rid = rid; v.roor = roor; v.daddr = 9'(daddr);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] x0, input logic [4:0] y0,
                       input logic v1, input logic [4:0] x1, input logic [4:0] y1);
    bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0;
    bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //                v0 x0 y0  v1 x1 y1  r0 r1 addr rv rid oor daddr
    vecs[0]  = mk(1, 3, 2,   0, 0, 0,   1, 0, 0,   0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0,   0, 0, 0,   0, 0, 43,  0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0,   0, 0, 0,   0, 0, 43,  1, 0, 0, 43);
    vecs[3]  = mk(1, 0, 0,   1, 19, 19, 0, 1, 43,  0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0,   1, 1, 0,   1, 0, 399, 0, 0, 0, 0);
    vecs[5]  = mk(1, 5, 1,   1, 1, 0,   0, 1, 0,   1, 1, 0, 399);
    vecs[6]  = mk(1, 5, 1,   1, 20, 0,  1, 0, 1,   1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0,   1, 20, 0,  0, 1, 25,  1, 1, 0, 1);
    vecs[8]  = mk(1, 0, 20,  0, 0, 0,   1, 0, 25,  1, 0, 0, 25);
    vecs[9]  = mk(0, 0, 0,   0, 0, 0,   0, 0, 25,  1, 1, 1, 0);
    vecs[10] = mk(0, 0, 0,   0, 0, 0,   0, 0, 25,  1, 0, 1, 0);
    vecs[11] = mk(0, 0, 0,   0, 0, 0,   0, 0, 25,  0, 0, 0, 0);
    vecs[12] = mk(1, 2, 2,   1, 4, 4,   0, 1, 25,  0, 0, 0, 0);
    vecs[13] = mk(1, 2, 2,   0, 0, 0,   1, 0, 84,  0, 0, 0, 0);
    vecs[14] = mk(1, 1, 1,   0, 0, 0,   1, 0, 42,  1, 1, 0, 84);
    vecs[15] = mk(1, 0, 1,   0, 0, 0,   1, 0, 21,  1, 0, 0, 42);
    vecs[16] = mk(1, 3, 3,   1, 6, 0,   0, 1, 20,  1, 0, 0, 21);
    vecs[17] = mk(1, 3, 3,   0, 0, 0,   1, 0, 6,   1, 0, 0, 20);
    vecs[18] = mk(0, 0, 0,   0, 0, 0,   0, 0, 63,  1, 1, 0, 6);
    vecs[19] = mk(0, 0, 0,   0, 0, 0,   0, 0, 63,  1, 0, 0, 63);
    for (int k = 20; k < 25; k++) begin
      vecs[k] = mk(0, 0, 0,  0, 0, 0,   0, 0, 63,  0, 0, 0, 0);
    end
    vecs[25] = mk(1, 1, 2,   1, 2, 1,   0, 1, 63,  0, 0, 0, 0);
    vecs[26] = mk(1, 1, 2,   0, 0, 0,   1, 0, 22,  0, 0, 0, 0);
    vecs[27] = mk(0, 0, 0,   0, 0, 0,   0, 0, 41,  1, 1, 0, 22);
    vecs[28] = mk(0, 0, 0,   0, 0, 0,   0, 0, 41,  1, 0, 0, 41);

    // Reset state, with both requesters asserting valid.
    Reset = 1'b1;
    drive(1'b1, 5'd3, 5'd2, 1'b1, 5'd4, 5'd4);
    @(negedge Clk);
    @(negedge Clk);
    #1;
    check("reset.ready0", 32'(bus.req0_ready), 32'd0);
    check("reset.ready1", 32'(bus.req1_ready), 32'd0);
    check("reset.rom_addr", 32'(bus.rom_addr), 32'd0);
    check("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset.rsp_id", 32'(bus.rsp_id), 32'd0);

    for (int i = 0; i < 29; i++) begin
      @(negedge Clk);
      if (i == 0) Reset = 1'b0;
      drive(vecs[i].v0, vecs[i].x0, vecs[i].y0, vecs[i].v1, vecs[i].x1, vecs[i].y1);
      #1;
      check($sformatf("v%0d.ready0", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
      check($sformatf("v%0d.ready1", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
      check($sformatf("v%0d.rom_addr", i), 32'(bus.rom_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].rv));
      if (vecs[i].rv) begin
        check($sformatf("v%0d.rsp_id", i), 32'(bus.rsp_id), 32'(vecs[i].rid));
        check($sformatf("v%0d.rsp_data", i), 32'(bus.rsp_data),
              vecs[i].roor ? 32'h0 : 32'(rom_word(vecs[i].daddr)));
      end
    end

    // Asynchronous reset between acceptance and ROM read: the request is dropped.
    @(negedge Clk);
    drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 5'd0);
    #1;
    check("arst.accept_ready0", 32'(bus.req0_ready), 32'd1);
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check("arst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst.rom_addr", 32'(bus.rom_addr), 32'd0);
    check("arst.ready0", 32'(bus.req0_ready), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge Clk);
      #1;
      check($sformatf("arst.no_rsp%0d", j), 32'(bus.rsp_valid), 32'd0);
    end
    @(negedge Clk);
    drive(1'b1, 5'd1, 5'd1, 1'b1, 5'd2, 5'd2);
    #1;
    check("arst.contend_ready0", 32'(bus.req0_ready), 32'd1);
    check("arst.contend_ready1", 32'(bus.req1_ready), 32'd0);
    @(negedge Clk);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 5'd2);
    #1;
    check("arst.after_rom_addr", 32'(bus.rom_addr), 32'd21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
